// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the 8-bit multicycle machine: opcodes, FSM states,
// ALU operand/op select codes and the packed control word.
package multicycle_control_fsm_pkg;

    localparam int OP_W    = 4;
    localparam int ALU2_W  = 3;
    localparam int ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_STOP  = 4'b0001;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0100;
    localparam logic [OP_W-1:0] OP_BZ    = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
    localparam logic [OP_W-1:0] OP_NAND  = 4'b1000;
    localparam logic [OP_W-1:0] OP_BNZ   = 4'b1001;
    localparam logic [OP_W-1:0] OP_BPZ   = 4'b1101;

    localparam logic [ALU2_W-1:0] ALU2_R2    = 3'b000;
    localparam logic [ALU2_W-1:0] ALU2_ONE   = 3'b001;
    localparam logic [ALU2_W-1:0] ALU2_SIMM4 = 3'b010;
    localparam logic [ALU2_W-1:0] ALU2_ZIMM5 = 3'b011;
    localparam logic [ALU2_W-1:0] ALU2_ZERO  = 3'b100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_NAND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_PASS = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_R_EX   = 4'd2,
        S_R_WB   = 4'd3,
        S_LD_MEM = 4'd4,
        S_LD_WB  = 4'd5,
        S_ST_MEM = 4'd6,
        S_ORI_EX = 4'd7,
        S_ORI_WB = 4'd8,
        S_BR_EX  = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    typedef struct packed {
        logic               pc_write;
        logic               pc_sel;
        logic               ir_load;
        logic               addr_sel;
        logic               mem_read;
        logic               mem_write;
        logic               mdr_load;
        logic               reg_write;
        logic               r1_sel;
        logic               reg_in_sel;
        logic               alu1_sel;
        logic [ALU2_W-1:0]  alu2_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic               flag_write;
        logic               halted;
    } ctrl_t;

    // ORI ignores ir[3], so it is matched on the low three opcode bits only.
    function automatic logic is_ori(input logic [OP_W-1:0] op);
        return op[2:0] == 3'b111;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the FSM (master) and the multicycle datapath (slave).
interface multicycle_control_fsm_if;
    import multicycle_control_fsm_pkg::*;

    logic [7:0]         ir;
    logic               z_flag;
    logic               n_flag;
    logic               pc_write;
    logic               pc_sel;
    logic               ir_load;
    logic               addr_sel;
    logic               mem_read;
    logic               mem_write;
    logic               mdr_load;
    logic               reg_write;
    logic               r1_sel;
    logic               reg_in_sel;
    logic               alu1_sel;
    logic [ALU2_W-1:0]  alu2_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               flag_write;
    logic               halted;

    modport master (
        input  ir, z_flag, n_flag,
        output pc_write, pc_sel, ir_load, addr_sel, mem_read, mem_write, mdr_load,
               reg_write, r1_sel, reg_in_sel, alu1_sel, alu2_sel, alu_op,
               flag_write, halted
    );

    modport slave (
        output ir, z_flag, n_flag,
        input  pc_write, pc_sel, ir_load, addr_sel, mem_read, mem_write, mdr_load,
               reg_write, r1_sel, reg_in_sel, alu1_sel, alu2_sel, alu_op,
               flag_write, halted
    );

endinterface

// File: rtl/multicycle_control_fsm_branch_cond_eval.sv
// Branch resolution: decides whether a conditional branch is taken from the
// opcode and the registered Z/N flags.
module branch_cond_eval
    import multicycle_control_fsm_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic            i_z,
    input  logic            i_n,
    output logic            o_taken
);

    always_comb begin
        case (i_op)
            OP_BZ:   o_taken = i_z;
            OP_BNZ:  o_taken = !i_z;
            OP_BPZ:  o_taken = !i_n;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the 8-bit multicycle datapath; the only input-dependent
// output is pc_write in BR_EX (branch taken).
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);

    state_e          r_state;
    state_e          w_next;
    logic [OP_W-1:0] r_op;
    logic            w_taken;
    ctrl_t           w_ctrl;

    // The opcode is captured on leaving DECODE so EX-state outputs decode only registered state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= bus.ir[OP_W-1:0];
        end
    end

    // NOTE: defaults are assigned first in every always_comb so no path can infer a latch.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (is_ori(bus.ir[OP_W-1:0])) begin
                    w_next = S_ORI_EX;
                end else begin
                    case (bus.ir[OP_W-1:0])
                        OP_ADD, OP_SUB, OP_NAND: w_next = S_R_EX;
                        OP_LOAD:                 w_next = S_LD_MEM;
                        OP_STORE:                w_next = S_ST_MEM;
                        OP_BZ, OP_BNZ, OP_BPZ:   w_next = S_BR_EX;
                        OP_STOP:                 w_next = S_HALT;
                        default:                 w_next = S_FETCH;
                    endcase
                end
            end
            S_R_EX:   w_next = S_R_WB;
            S_LD_MEM: w_next = S_LD_WB;
            S_ORI_EX: w_next = S_ORI_WB;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    branch_cond_eval u_branch (
        .i_op    (r_op),
        .i_z     (bus.z_flag),
        .i_n     (bus.n_flag),
        .o_taken (w_taken)
    );

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ir_load  = 1'b1;
                w_ctrl.alu2_sel = ALU2_ONE;
                w_ctrl.alu_op   = ALUOP_ADD;
                w_ctrl.pc_write = 1'b1;
            end
            S_R_EX: begin
                w_ctrl.alu1_sel   = 1'b1;
                w_ctrl.alu2_sel   = ALU2_R2;
                w_ctrl.flag_write = 1'b1;
                case (r_op)
                    OP_SUB:  w_ctrl.alu_op = ALUOP_SUB;
                    OP_NAND: w_ctrl.alu_op = ALUOP_NAND;
                    default: w_ctrl.alu_op = ALUOP_ADD;
                endcase
            end
            S_R_WB:   w_ctrl.reg_write = 1'b1;
            S_LD_MEM: begin
                w_ctrl.addr_sel = 1'b1;
                w_ctrl.mem_read = 1'b1;
                w_ctrl.mdr_load = 1'b1;
            end
            S_LD_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_in_sel = 1'b1;
            end
            S_ST_MEM: begin
                w_ctrl.addr_sel  = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_ORI_EX: begin
                w_ctrl.r1_sel     = 1'b1;
                w_ctrl.alu1_sel   = 1'b1;
                w_ctrl.alu2_sel   = ALU2_ZIMM5;
                w_ctrl.alu_op     = ALUOP_OR;
                w_ctrl.flag_write = 1'b1;
            end
            S_ORI_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.r1_sel    = 1'b1;
            end
            S_BR_EX: begin
                w_ctrl.alu2_sel = ALU2_SIMM4;
                w_ctrl.alu_op   = ALUOP_ADD;
                w_ctrl.pc_write = w_taken;
            end
            S_HALT:   w_ctrl.halted = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

    assign bus.pc_write   = w_ctrl.pc_write;
    assign bus.pc_sel     = w_ctrl.pc_sel;
    assign bus.ir_load    = w_ctrl.ir_load;
    assign bus.addr_sel   = w_ctrl.addr_sel;
    assign bus.mem_read   = w_ctrl.mem_read;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.mdr_load   = w_ctrl.mdr_load;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.r1_sel     = w_ctrl.r1_sel;
    assign bus.reg_in_sel = w_ctrl.reg_in_sel;
    assign bus.alu1_sel   = w_ctrl.alu1_sel;
    assign bus.alu2_sel   = w_ctrl.alu2_sel;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.flag_write = w_ctrl.flag_write;
    assign bus.halted     = w_ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each stimulus step queues the control word expected after
// the next rising edge; a negedge monitor pops and compares.
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    typedef enum int {E_FETCH, E_DECODE, E_REX, E_RWB, E_LDMEM, E_LDWB, E_STMEM,
                      E_ORIEX, E_ORIWB, E_BREX, E_HALT} exp_state_e;

    typedef struct {
        ctrl_t ctrl;
        string name;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Hand-written expected control words, one per state.
    function automatic ctrl_t exp_of(input exp_state_e s, input logic [2:0] aop, input logic taken);
        ctrl_t c;
        c = '0;
        case (s)
            E_FETCH:  begin c.mem_read = 1; c.ir_load = 1; c.pc_write = 1; c.alu2_sel = 3'b001; end
            E_REX:    begin c.alu1_sel = 1; c.alu2_sel = 3'b000; c.alu_op = aop; c.flag_write = 1; end
            E_RWB:    c.reg_write = 1;
            E_LDMEM:  begin c.addr_sel = 1; c.mem_read = 1; c.mdr_load = 1; end
            E_LDWB:   begin c.reg_write = 1; c.reg_in_sel = 1; end
            E_STMEM:  begin c.addr_sel = 1; c.mem_write = 1; end
            E_ORIEX:  begin c.r1_sel = 1; c.alu1_sel = 1; c.alu2_sel = 3'b011; c.alu_op = 3'b011; c.flag_write = 1; end
            E_ORIWB:  begin c.reg_write = 1; c.r1_sel = 1; end
            E_BREX:   begin c.alu2_sel = 3'b010; c.pc_write = taken; end
            E_HALT:   c.halted = 1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic vec(input logic rst, input logic [7:0] ir_v, input logic z, input logic n,
                       input exp_state_e s, input logic [2:0] aop, input logic taken, input string name);
        exp_t e;
        reset      = rst;
        bus.ir     = ir_v;
        bus.z_flag = z;
        bus.n_flag = n;
        e.ctrl = exp_of(s, aop, taken);
        e.name = name;
        q.push_back(e);
        @(negedge clock);
        #1;
    endtask

    task automatic run_rtype(input logic [7:0] ir_v, input logic [2:0] aop, input string name);
        vec(0, ir_v, 0, 0, E_DECODE, 0, 0, {name, "_dec"});
        vec(0, ir_v, 0, 0, E_REX, aop, 0, {name, "_ex"});
        vec(0, ir_v, 0, 0, E_RWB, 0, 0, {name, "_wb"});
        vec(0, ir_v, 0, 0, E_FETCH, 0, 0, {name, "_fetch"});
    endtask

    task automatic run_branch(input logic [7:0] ir_v, input logic z, input logic n,
                              input logic taken, input string name);
        vec(0, ir_v, z, n, E_DECODE, 0, 0, {name, "_dec"});
        vec(0, ir_v, z, n, E_BREX, 0, taken, {name, "_ex"});
        vec(0, ir_v, z, n, E_FETCH, 0, 0, {name, "_fetch"});
    endtask

    function automatic ctrl_t sample();
        ctrl_t c;
        c.pc_write   = bus.pc_write;
        c.pc_sel     = bus.pc_sel;
        c.ir_load    = bus.ir_load;
        c.addr_sel   = bus.addr_sel;
        c.mem_read   = bus.mem_read;
        c.mem_write  = bus.mem_write;
        c.mdr_load   = bus.mdr_load;
        c.reg_write  = bus.reg_write;
        c.r1_sel     = bus.r1_sel;
        c.reg_in_sel = bus.reg_in_sel;
        c.alu1_sel   = bus.alu1_sel;
        c.alu2_sel   = bus.alu2_sel;
        c.alu_op     = bus.alu_op;
        c.flag_write = bus.flag_write;
        c.halted     = bus.halted;
        return c;
    endfunction

    task automatic check(input string name, input ctrl_t got, input ctrl_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, sample(), e.ctrl);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges, FETCH decoded in both following cycles.
        vec(1, 8'h00, 0, 0, E_FETCH, 0, 0, "rst0");
        vec(1, 8'h00, 0, 0, E_FETCH, 0, 0, "rst1");

        run_rtype(8'b0110_0100, 3'b000, "add");
        run_rtype(8'b0001_0110, 3'b001, "sub");
        run_rtype(8'b1110_1000, 3'b010, "nand");

        vec(0, 8'h00, 0, 0, E_DECODE, 0, 0, "ld_dec");
        vec(0, 8'h00, 0, 0, E_LDMEM, 0, 0, "ld_mem");
        vec(0, 8'h00, 0, 0, E_LDWB, 0, 0, "ld_wb");
        vec(0, 8'h00, 0, 0, E_FETCH, 0, 0, "ld_fetch");

        vec(0, 8'h92, 0, 0, E_DECODE, 0, 0, "st_dec");
        vec(0, 8'h92, 0, 0, E_STMEM, 0, 0, "st_mem");
        vec(0, 8'h92, 0, 0, E_FETCH, 0, 0, "st_fetch");

        run_branch(8'b1111_0101, 1, 0, 1, "bz_t");
        run_branch(8'b1111_0101, 0, 1, 0, "bz_nt");
        run_branch(8'b0011_1001, 0, 1, 1, "bnz_t");
        run_branch(8'b0011_1001, 1, 0, 0, "bnz_nt");
        run_branch(8'b1000_1101, 1, 0, 1, "bpz_t");
        run_branch(8'b1000_1101, 0, 1, 0, "bpz_nt");

        vec(0, 8'b0001_0111, 0, 0, E_DECODE, 0, 0, "ori_dec");
        vec(0, 8'b0001_0111, 0, 0, E_ORIEX, 0, 0, "ori_ex");
        vec(0, 8'b0001_0111, 0, 0, E_ORIWB, 0, 0, "ori_wb");
        vec(0, 8'b0001_0111, 0, 0, E_FETCH, 0, 0, "ori_fetch");

        // ORI with ir[3]=1 is still ORI.
        vec(0, 8'hAF, 0, 0, E_DECODE, 0, 0, "ori8_dec");
        vec(0, 8'hAF, 0, 0, E_ORIEX, 0, 0, "ori8_ex");
        vec(0, 8'hAF, 0, 0, E_ORIWB, 0, 0, "ori8_wb");
        vec(0, 8'hAF, 0, 0, E_FETCH, 0, 0, "ori8_fetch");

        // Unassigned opcodes behave as two-cycle NOPs.
        vec(0, 8'h53, 0, 0, E_DECODE, 0, 0, "nop3_dec");
        vec(0, 8'h53, 0, 0, E_FETCH, 0, 0, "nop3_fetch");
        vec(0, 8'h0C, 0, 0, E_DECODE, 0, 0, "nopc_dec");
        vec(0, 8'h0C, 0, 0, E_FETCH, 0, 0, "nopc_fetch");

        vec(0, 8'h01, 0, 0, E_DECODE, 0, 0, "stop_dec");
        for (int i = 0; i < 12; i++)
            vec(0, (i[0] ? 8'h64 : 8'h01), i[1], i[2], E_HALT, 0, 0, $sformatf("halt%0d", i));

        // Reset leaves HALT.
        vec(1, 8'h64, 0, 0, E_FETCH, 0, 0, "halt_rst");
        vec(0, 8'h64, 0, 0, E_DECODE, 0, 0, "rx_dec");
        vec(0, 8'h64, 0, 0, E_REX, 3'b000, 0, "rx_ex");
        // Reset in R_EX: the writeback is dropped.
        vec(1, 8'h64, 0, 0, E_FETCH, 0, 0, "rx_rst");
        vec(0, 8'h00, 0, 0, E_DECODE, 0, 0, "ldx_dec");
        vec(0, 8'h00, 0, 0, E_LDMEM, 0, 0, "ldx_mem");
        vec(1, 8'h00, 0, 0, E_FETCH, 0, 0, "ldx_rst");
        run_rtype(8'b0110_0100, 3'b000, "add2");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected words left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
